pc_register: RTL

- Program-counter register for the gate-level CPU.
- Sits directly downstream of the gated D-latch: pairs of latches form master-slave edge-triggered flip-flops, and WIDTH of those hold the PC.
- Per rising clock edge it holds, increments (ripple-carry incrementer built from half adders), or parallel-loads a jump target.
- Output feeds instruction-fetch addressing.

---
 rtl/pc_register_pkg.sv | 30 +++
 rtl/pc_register_if.sv | 24 ++
 rtl/pc_register_dff_ar.sv | 24 ++
 rtl/pc_register.sv | 113 +++++++++++
 4 files changed

// File: rtl/pc_register_pkg.sv
// Shared CPU definitions for the program counter: default width/reset vector
// and the operation priority encoding used by the control unit.
package pc_register_pkg;

    localparam int unsigned CPU_PC_WIDTH     = 8;
    localparam int unsigned CPU_RESET_VECTOR = 0;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_INC    = 2'd1,
        OP_BRANCH = 2'd2,
        OP_LOAD   = 2'd3
    } pc_op_e;

    // LOAD beats BRANCH beats INC; nothing asserted means hold.
    function automatic pc_op_e pc_op_decode(input logic load, input logic branch,
                                            input logic inc);
        pc_op_e op;
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (branch) begin
            op = OP_BRANCH;
        end else if (inc) begin
            op = OP_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_register_if.sv
// Control/data bundle between the control unit (master) and the PC (slave).
// BRANCH/OFFSET exist only when PC_RELATIVE_EN is defined.
interface pc_register_if #(
    parameter int unsigned WIDTH = pc_register_pkg::CPU_PC_WIDTH
);
    logic             load;
    logic             inc;
    logic [WIDTH-1:0] d;
`ifdef PC_RELATIVE_EN
    logic             branch;
    logic [WIDTH-1:0] offset;
`endif
    logic [WIDTH-1:0] q;
    logic             wrap;

`ifdef PC_RELATIVE_EN
    modport master (output load, inc, d, branch, offset, input q, wrap);
    modport slave  (input load, inc, d, branch, offset, output q, wrap);
`else
    modport master (output load, inc, d, input q, wrap);
    modport slave  (input load, inc, d, output q, wrap);
`endif

endinterface

// File: rtl/pc_register_dff_ar.sv
// Rising-edge flip-flop with active-low asynchronous clear/preset; INIT picks
// the value held while rst_n is low. Stands in for a master-slave latch pair.
module dff_ar #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/pc_register.sv
// Program-counter register: hold / half-adder ripple increment / parallel load.
// Optional PC-relative branch adder enabled by defining PC_RELATIVE_EN.
module pc_register
    import pc_register_pkg::*;
#(
    parameter int unsigned WIDTH        = CPU_PC_WIDTH,
    parameter int unsigned RESET_VECTOR = CPU_RESET_VECTOR
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic             INC,
    input  logic [WIDTH-1:0] D,
`ifdef PC_RELATIVE_EN
    input  logic             BRANCH,
    input  logic [WIDTH-1:0] OFFSET,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] RV = RESET_VECTOR[WIDTH-1:0];

    pc_op_e           op;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_cout;
`ifdef PC_RELATIVE_EN
    logic [WIDTH-1:0] br_sum;
`endif

`ifdef PC_RELATIVE_EN
    assign op = pc_op_decode(LOAD, BRANCH, INC);
`else
    assign op = pc_op_decode(LOAD, 1'b0, INC);
`endif

    // Carry-in is INC itself, so with INC low the sum is Q and hold falls out free.
    always_comb begin
        logic [WIDTH:0] c;
        c       = '0;
        inc_sum = '0;
        c[0]    = INC;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            inc_sum[i] = pc_q[i] ^ c[i];
            c[i+1]     = pc_q[i] & c[i];
        end
        inc_cout = c[WIDTH];
    end

`ifdef PC_RELATIVE_EN
    always_comb begin
        logic [WIDTH-1:0] c;
        logic             p;
        c      = '0;
        br_sum = '0;
        p      = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            p         = pc_q[i] ^ OFFSET[i];
            br_sum[i] = p ^ c[i];
            if (i + 1 < WIDTH) begin
                c[i+1] = (pc_q[i] & OFFSET[i]) | (p & c[i]);
            end
        end
    end
`endif

    always_comb begin
        logic sel_load;
        logic sel_br;
        logic mid;
        pc_d     = '0;
        mid      = 1'b0;
        sel_load = (op == OP_LOAD);
`ifdef PC_RELATIVE_EN
        sel_br   = (op == OP_BRANCH);
`else
        sel_br   = 1'b0;
`endif
        for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef PC_RELATIVE_EN
            mid = (sel_br & br_sum[i]) | (~sel_br & inc_sum[i]);
`else
            mid = inc_sum[i];
`endif
            pc_d[i] = (sel_load & D[i]) | (~sel_load & mid);
        end
        wrap_d = (op == OP_INC) & inc_cout & ~sel_br;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pc
        dff_ar #(.INIT(RV[i])) u_bit (
            .clk   (CLK),
            .rst_n (RST_N),
            .d     (pc_d[i]),
            .q     (pc_q[i])
        );
    end

    dff_ar #(.INIT(1'b0)) u_wrap (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (wrap_d),
        .q     (wrap_q)
    );

    assign Q    = pc_q;
    assign WRAP = wrap_q;

endmodule
